conv_scratchpad: RTL
====================

CONV_SCRATCHPAD -- requirements
Module: conv_scratchpad

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, giving word depth 2^ADDR_BITS of 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving cycles from request accept to done pulse; legal range 1..15.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 eng_mem_operation  input  2  engine request: 01 read, 11 write, 00 none, 10 reserved.
REQ-006 eng_addr  input  32  engine word address.
REQ-007 eng_wdata  input  32  engine write data.
REQ-008 eng_rdata  output  32  engine read data.
REQ-009 eng_opdone  output  1  one-cycle completion pulse to engine.
REQ-010 host_req  input  1  host access request, level, held until host_ack.
REQ-011 host_we  input  1  host write (1) / read (0).
REQ-012 host_addr  input  ADDR_BITS  host word address.
REQ-013 host_wdata  input  32  host write data.
REQ-014 host_rdata  output  32  host read data.
REQ-015 host_ack  output  1  one-cycle host completion pulse.
REQ-016 busy  output  1  high whenever the FSM is not IDLE.
REQ-017 addr_err  output  1  sticky flag: engine address out of range.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, RESPOND.
REQ-019 In IDLE, eng_mem_operation 01 or 11 SHALL be accepted: op, eng_addr, eng_wdata latched; next state WAIT (or RESPOND if LATENCY=1).
REQ-020 In IDLE with no engine request and host_req=1, the host request SHALL be accepted with identical latching and timing; the engine wins simultaneous requests.
REQ-021 Codes 00 and 10 SHALL be ignored in IDLE.
REQ-022 WAIT SHALL count LATENCY-1 cycles, then enter RESPOND; inputs during WAIT and RESPOND are not sampled.
REQ-023 RESPOND SHALL last one cycle, drive eng_opdone=1 (engine access) or host_ack=1 (host access), then return to IDLE; the done pulse is therefore exactly LATENCY cycles after the accept edge.
REQ-024 Reads: eng_rdata/host_rdata SHALL show the addressed word during RESPOND and hold it until the next completed read on that port.
REQ-025 Writes SHALL be committed to memory at the RESPOND edge only.
REQ-026 After RESPOND, at least one IDLE cycle SHALL occur before the next accept, so a requester that updates its address on the done edge gets its new address sampled.
REQ-027 Engine address >= 2^ADDR_BITS: read returns 0, write is dropped, addr_err set, done pulse still issued; addr_err clears only on reset.
REQ-028 Host addresses SHALL always be in range (width-limited); no error path.
REQ-029 Read-after-write to the same address SHALL return the new data.

Reset
REQ-030 On reset: state IDLE, eng_rdata=0, host_rdata=0, eng_opdone=0, host_ack=0, busy=0, addr_err=0, wait counter 0.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 Reset during WAIT or RESPOND SHALL abort the access: no write committed, no done pulse.

Verification
REQ-033 Host writes 5,7,3,3 to addr 1..4, then engine reads addr 1 held (op=01) -> eng_opdone at accept+2, eng_rdata=5.
REQ-034 Engine sequential reads with addr incremented on each opdone, op held at 01 -> four pulses returning 5,7,3,3 in order, no duplicate or skipped word.
REQ-035 Engine write 0x0000_002A to addr 0x20, then host read 0x20 -> host_ack with host_rdata=0x2A.
REQ-036 host_req and engine read asserted in the same IDLE cycle -> engine served first, host_ack LATENCY+1 cycles after eng_opdone.
REQ-037 Engine write to addr 0x100 -> opdone issued, addr_err=1, no memory word altered; host read of addr 0x00 unchanged.
REQ-038 Reset asserted in WAIT of engine write 0xFFFF to addr 9 -> no opdone, addr 9 keeps previous value, busy=0 after reset.

Source files
------------

// File: rtl/conv_scratchpad.sv
// rtl/conv_scratchpad.sv - Shared word scratchpad with fixed-latency engine and host ports
// The engine port has priority over the host port. Only one access is in flight at a time.
module conv_scratchpad #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           eng_mem_operation,
    input  logic [31:0]          eng_addr,
    input  logic [31:0]          eng_wdata,
    output logic [31:0]          eng_rdata,
    output logic                 eng_opdone,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [31:0]          host_wdata,
    output logic [31:0]          host_rdata,
    output logic                 host_ack,
    output logic                 busy,
    output logic                 addr_err
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t state, state_next;

    logic [31:0]          mem [DEPTH];
    logic [3:0]           wait_cnt;
    logic                 acc_host;
    logic                 acc_we;
    logic                 acc_oor;
    logic [ADDR_BITS-1:0] acc_addr;
    logic [31:0]          acc_wdata;

    logic                 eng_req;
    logic                 eng_oor;
    logic                 accept;
    logic                 enter_respond;
    logic                 sel_host;
    logic                 sel_we;
    logic                 sel_oor;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [31:0]          sel_wdata;
    logic [31:0]          rd_word;

    // Codes 01 and 11 are the only ones with bit 0 set.
    assign eng_req = eng_mem_operation[0];
    assign eng_oor = (eng_addr >> ADDR_BITS) != 32'd0;
    assign accept  = (state == S_IDLE) && (eng_req || host_req);

    // In IDLE the live request is used, so LATENCY=1 can read at the accept edge.
    always_comb begin
        sel_host  = acc_host;
        sel_we    = acc_we;
        sel_oor   = acc_oor;
        sel_addr  = acc_addr;
        sel_wdata = acc_wdata;
        if (state == S_IDLE) begin
            if (eng_req) begin
                sel_host  = 1'b0;
                sel_we    = eng_mem_operation[1];
                sel_oor   = eng_oor;
                sel_addr  = eng_addr[ADDR_BITS-1:0];
                sel_wdata = eng_wdata;
            end else begin
                sel_host  = 1'b1;
                sel_we    = host_we;
                sel_oor   = 1'b0;
                sel_addr  = host_addr;
                sel_wdata = host_wdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? S_RESPOND : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = S_RESPOND;
                end
            end
            S_RESPOND: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    assign enter_respond = (state != S_RESPOND) && (state_next == S_RESPOND);
    assign rd_word       = sel_oor ? 32'd0 : mem[sel_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            acc_host   <= 1'b0;
            acc_we     <= 1'b0;
            acc_oor    <= 1'b0;
            acc_addr   <= '0;
            acc_wdata  <= 32'd0;
            eng_rdata  <= 32'd0;
            host_rdata <= 32'd0;
            addr_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                wait_cnt  <= 4'd0;
                acc_host  <= sel_host;
                acc_we    <= sel_we;
                acc_oor   <= sel_oor;
                acc_addr  <= sel_addr;
                acc_wdata <= sel_wdata;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (enter_respond && !sel_we) begin
                if (sel_host) begin
                    host_rdata <= rd_word;
                end else begin
                    eng_rdata <= rd_word;
                end
            end
            if (enter_respond && sel_oor) begin
                addr_err <= 1'b1;
            end
        end
    end

    // Storage is never cleared; a write lands only when RESPOND completes without reset.
    always_ff @(posedge clk) begin
        if (!reset && (state == S_RESPOND) && acc_we && !acc_oor) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    assign eng_opdone = (state == S_RESPOND) && !acc_host && !reset;
    assign host_ack   = (state == S_RESPOND) && acc_host && !reset;
    assign busy       = (state != S_IDLE);

endmodule
